// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; never below one bit.
  function automatic int cnt_bits(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for the level start request.
// One register of history; rise is combinational from it.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= in;
    end
  end

  assign rise = in & ~start_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving an external full adder,
// LSB first, one bit-slice per clock while busy.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             rise;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (start),
    .rise  (rise)
  );

  // Result bits enter at the MSB so the first slice ends at bit 0.
  assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};

  assign fa_a   = (state == RUN) & a_sr[0];
  assign fa_b   = (state == RUN) & b_sr[0];
  assign fa_cin = (state == RUN) & carry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (rise) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_next;
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
